// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite read engine.
// Coordinates are 10-bit unsigned; RAM addresses are 19-bit.
package sprite_pkg;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 19;

  typedef logic [3:0]         pal_idx_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

  typedef struct packed {
    coord_t     x;
    coord_t     y;
    logic       flip;
    logic [7:0] frame;
    logic       enable;
  } shadow_t;

  // Out-of-range animation frames fold onto the last stored frame.
  function automatic logic [7:0] clamp_frame(input logic [7:0] sel, input int frames);
    if (int'(sel) >= frames) return 8'(frames - 1);
    return sel;
  endfunction

endpackage

// File: rtl/sprite_shadow_regs.sv
// Sprite placement registers, reloaded only on the frame_start pulse
// so a sprite cannot move or change frame part-way down the screen.
module sprite_shadow_regs
  import sprite_pkg::*;
#(
  parameter int FRAMES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  coord_t     i_x,
  input  coord_t     i_y,
  input  logic       i_flip,
  input  logic [7:0] i_frame_sel,
  input  logic       i_enable,
  output shadow_t    o_shadow
);

  shadow_t r_shadow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= '{x:      i_x,
                    y:      i_y,
                    flip:   i_flip,
                    frame:  clamp_frame(i_frame_sel, FRAMES),
                    enable: i_enable};
    end
  end

  assign o_shadow = r_shadow;

endmodule

// File: rtl/sprite_fetch.sv
// Sprite read engine: box test and RAM address on stage 1, RAM access on
// stage 2, registered palette index with valid/opaque flags on stage 3.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int       SPR_W       = 20,
  parameter int       SPR_H       = 40,
  parameter int       FRAMES      = 1,
  parameter pal_idx_t TRANSPARENT = TRANSPARENT_IDX
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         pix_en,
  input  coord_t       DrawX,
  input  coord_t       DrawY,
  input  logic         frame_start,
  input  coord_t       SpriteX,
  input  coord_t       SpriteY,
  input  logic         flip_h,
  input  logic [7:0]   frame_sel,
  input  logic         spr_enable,
  output addr_t        READ_ADDR,
  input  pal_idx_t     ram_data,
  output logic         pix_valid,
  output logic         pix_opaque,
  output pal_idx_t     pix_idx
);

  localparam coord_t W_C      = COORD_W'(SPR_W);
  localparam coord_t H_C      = COORD_W'(SPR_H);
  localparam coord_t W_M1     = COORD_W'(SPR_W - 1);
  localparam addr_t  ROW_SZ   = ADDR_W'(SPR_W);
  localparam addr_t  FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

  shadow_t  w_shadow;
  coord_t   w_dx;
  coord_t   w_dy;
  coord_t   w_col;
  logic     w_in_box;
  logic     w_opaque;
  addr_t    w_frame_base;
  addr_t    w_addr;

  addr_t    r_read_addr;
  logic     r_v1;
  logic     r_b1;
  logic     r_v2;
  logic     r_b2;
  logic     r_pix_valid;
  logic     r_pix_opaque;
  pal_idx_t r_pix_idx;

  sprite_shadow_regs #(
    .FRAMES (FRAMES)
  ) u_shadow (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_load      (frame_start),
    .i_x         (SpriteX),
    .i_y         (SpriteY),
    .i_flip      (flip_h),
    .i_frame_sel (frame_sel),
    .i_enable    (spr_enable),
    .o_shadow    (w_shadow)
  );

  // dx/dy wrap when the pixel is left of or above the box; the explicit
  // >= compares reject those cases before the range checks are trusted.
  always_comb begin
    w_dx         = DrawX - w_shadow.x;
    w_dy         = DrawY - w_shadow.y;
    w_in_box     = (DrawX >= w_shadow.x) && (DrawY >= w_shadow.y) &&
                   (w_dx < W_C) && (w_dy < H_C) && w_shadow.enable;
    w_col        = w_shadow.flip ? (W_M1 - w_dx) : w_dx;
    w_frame_base = ADDR_W'(w_shadow.frame) * FRAME_SZ;
    w_addr       = w_frame_base + ADDR_W'(w_dy) * ROW_SZ + ADDR_W'(w_col);
    w_opaque     = r_v2 && r_b2 && (ram_data != TRANSPARENT);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_read_addr  <= '0;
      r_v1         <= 1'b0;
      r_b1         <= 1'b0;
      r_v2         <= 1'b0;
      r_b2         <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_opaque <= 1'b0;
      r_pix_idx    <= '0;
    end else begin
      // Outside the box the address is parked to keep the RAM quiet.
      if (w_in_box) r_read_addr <= w_addr;
      r_v1         <= pix_en;
      r_b1         <= w_in_box;
      r_v2         <= r_v1;
      r_b2         <= r_b1;
      r_pix_valid  <= r_v2;
      r_pix_opaque <= w_opaque;
      r_pix_idx    <= w_opaque ? ram_data : '0;
    end
  end

  assign READ_ADDR  = r_read_addr;
  assign pix_valid  = r_pix_valid;
  assign pix_opaque = r_pix_opaque;
  assign pix_idx    = r_pix_idx;

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: a coordinate-level sprite model feeds
// an expected-pixel queue that a negedge monitor drains on pix_valid.
module tb_sprite_fetch;

  localparam int SPR_W  = 20;
  localparam int SPR_H  = 40;
  localparam int FRAMES = 3;
  localparam int MEM_SZ = SPR_W * SPR_H * FRAMES;
  localparam logic [3:0] TRANSP = 4'h0;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  SpriteX = '0;
  logic [9:0]  SpriteY = '0;
  logic        flip_h = 1'b0;
  logic [7:0]  frame_sel = '0;
  logic        spr_enable = 1'b0;
  logic [18:0] READ_ADDR;
  logic [3:0]  ram_data = '0;
  logic        pix_valid;
  logic        pix_opaque;
  logic [3:0]  pix_idx;

  always #5 CLK = ~CLK;

  sprite_fetch #(
    .SPR_W       (SPR_W),
    .SPR_H       (SPR_H),
    .FRAMES      (FRAMES),
    .TRANSPARENT (TRANSP)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .pix_en      (pix_en),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .SpriteX     (SpriteX),
    .SpriteY     (SpriteY),
    .flip_h      (flip_h),
    .frame_sel   (frame_sel),
    .spr_enable  (spr_enable),
    .READ_ADDR   (READ_ADDR),
    .ram_data    (ram_data),
    .pix_valid   (pix_valid),
    .pix_opaque  (pix_opaque),
    .pix_idx     (pix_idx)
  );

  // Palette-index RAM with a one-cycle registered read.
  logic [3:0] mem [MEM_SZ];
  always @(posedge CLK)
    ram_data <= (int'(READ_ADDR) < MEM_SZ) ? mem[int'(READ_ADDR)] : 4'h0;

  typedef struct {
    int         stamp;
    int         px;
    int         py;
    bit         opaque;
    logic [3:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference sprite state as the screen should currently see it.
  int mx, my, mframe, maddr;
  bit mflip, men;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RESET && pix_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_valid: pix_valid=1 with no pixel expected at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if ((cyc - e.stamp) != 3 || pix_opaque !== e.opaque || pix_idx !== e.idx) begin
          n_fail++;
          $display("FAIL pixel(%0d,%0d): got latency=%0d opaque=%0b idx=%h, want latency=3 opaque=%0b idx=%h",
                   e.px, e.py, cyc - e.stamp, pix_opaque, pix_idx, e.opaque, e.idx);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mframe = 0; maddr = 0; mflip = 0; men = 0;
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic drive(input bit pe, input int x, input int y, input bit fs);
    int   ddx, ddy, addr;
    bit   inb;
    exp_t e;
    pix_en      = pe;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    frame_start = fs;
    ddx  = int'(DrawX) - mx;
    ddy  = int'(DrawY) - my;
    inb  = men && ddx >= 0 && ddx < SPR_W && ddy >= 0 && ddy < SPR_H;
    addr = mframe * SPR_W * SPR_H + ddy * SPR_W + (mflip ? SPR_W - 1 - ddx : ddx);
    if (inb) maddr = addr;
    if (pe) begin
      e.stamp  = cyc;
      e.px     = int'(DrawX);
      e.py     = int'(DrawY);
      e.opaque = inb && (mem[addr] != TRANSP);
      e.idx    = e.opaque ? mem[addr] : 4'h0;
      exp_q.push_back(e);
    end
    if (fs) begin
      mx     = int'(SpriteX);
      my     = int'(SpriteY);
      mflip  = flip_h;
      men    = spr_enable;
      mframe = (int'(frame_sel) >= FRAMES) ? FRAMES - 1 : int'(frame_sel);
    end
    @(posedge CLK);
    #1;
    check("read_addr", READ_ADDR, maddr);
    pix_en      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic load(input int sx, input int sy, input bit fl, input int fsel, input bit en);
    SpriteX    = 10'(sx);
    SpriteY    = 10'(sy);
    flip_h     = fl;
    frame_sel  = 8'(fsel);
    spr_enable = en;
    drive(0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 4'($urandom);
    mem[5] = TRANSP;
    mem[6] = 4'h9;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_read_addr", READ_ADDR, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_opaque", pix_opaque, 0);
    check("rst_pix_idx", pix_idx, 0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Horizontal sweep across the box, including both edges.
    load(100, 50, 0, 0, 1);
    for (int x = 98; x <= 121; x++) begin
      drive(1, x, 50, 0);
      if (x == 100) check("sweep_first_addr", READ_ADDR, 0);
      if (x == 119) check("sweep_last_addr", READ_ADDR, 19);
    end

    load(100, 50, 1, 0, 1);
    drive(1, 100, 51, 0);
    check("flip_left_addr", READ_ADDR, 39);
    drive(1, 119, 51, 0);
    check("flip_right_addr", READ_ADDR, 20);

    load(100, 50, 0, 2, 1);
    drive(1, 100, 50, 0);
    check("frame2_addr", READ_ADDR, 1600);
    load(100, 50, 0, 7, 1);
    drive(1, 101, 50, 0);
    drive(1, 100, 50, 0);
    check("frame_clamp_addr", READ_ADDR, 1600);

    // Mid-frame position change must wait for frame_start.
    load(100, 50, 0, 0, 1);
    SpriteX = 10'd300;
    drive(1, 100, 50, 0);
    drive(1, 300, 50, 0);
    drive(1, 101, 50, 1);
    drive(1, 101, 50, 0);
    drive(1, 301, 50, 0);

    // Randomised traffic with occasional reloads.
    for (int i = 0; i < 500; i++) begin
      if (($urandom % 40) == 0) begin
        SpriteX    = 10'($urandom_range(0, 1023));
        SpriteY    = 10'($urandom_range(0, 1023));
        flip_h     = 1'($urandom);
        frame_sel  = 8'($urandom_range(0, 7));
        spr_enable = ($urandom % 8) != 0;
        drive(($urandom % 4) != 0, mx + int'($urandom_range(0, 30)) - 5,
              my + int'($urandom_range(0, 50)) - 5, 1);
      end else begin
        drive(($urandom % 4) != 0, mx + int'($urandom_range(0, 30)) - 5,
              my + int'($urandom_range(0, 50)) - 5, 0);
      end
    end

    // Reset with pixels in flight.
    load(200, 100, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 200 + i, 100, 0);
    check("valid_before_reset", pix_valid, 1);
    RESET = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("valid_on_reset", pix_valid, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("valid_after_reset", pix_valid, 0);
    end

    // Sprite stays hidden until a new frame_start.
    for (int i = 0; i < 4; i++) drive(1, 202 + i, 100, 0);
    load(200, 100, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 202 + i, 100, 0);

    repeat (8) @(posedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Read-side engine for the per-sprite palette-index RAMs. For each pixel coordinate from the VGA controller, it decides whether the pixel falls inside the sprite box and issues the matching RAM read address. It then aligns the returned 4-bit palette index with a valid/opaque flag for the colour mapper. Sprite position, flip and animation frame are double-buffered and change only at frame start, so the sprite never tears mid-frame.

## Interface
Parameters:
- SPR_W, 20, sprite width in pixels.
- SPR_H, 40, sprite height in pixels.
- FRAMES, 1, number of animation frames stored back-to-back in the RAM (frame f occupies addresses f*SPR_W*SPR_H onward).
- TRANSPARENT, 4'h0, palette index treated as see-through (pink key).

Ports:
- CLK  in  1  system clock; only clock.
- RESET  in  1  asynchronous, active-high reset.
- pix_en  in  1  qualifies DrawX/DrawY this cycle.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- frame_start  in  1  one-cycle pulse at start of vertical blank; loads shadow registers.
- SpriteX, SpriteY  in  10 each  requested top-left corner (unsigned).
- flip_h  in  1  mirror the sprite horizontally.
- frame_sel  in  8  requested animation frame.
- spr_enable  in  1  sprite shown this frame.
- READ_ADDR  out  19  to RAM read port, registered.
- ram_data  in  4  RAM data_out (1-cycle registered read).
- pix_valid  out  1  pipeline output qualifier.
- pix_opaque  out  1  inside box, enabled, and index != TRANSPARENT.
- pix_idx  out  4  palette index (0 when not opaque).

## Operation
- Shadow registers (x, y, flip, frame, enable) load from the inputs on the edge where frame_start=1. All other cycles hold. Reset value: all zero, enable=0.
- frame_sel >= FRAMES loads as FRAMES-1.
- Stage 1 (edge after pix_en sample):
  - dx = DrawX - x, dy = DrawY - y, as 10-bit unsigned.
  - in_box = DrawX>=x && DrawY>=y && dx<SPR_W && dy<SPR_H && enable.
  - col = flip ? SPR_W-1-dx : dx.
  - READ_ADDR <= frame*SPR_W*SPR_H + dy*SPR_W + col, computed at 19 bits with no truncation of the intermediates.
  - When not in_box, READ_ADDR holds its previous value, so the RAM does not toggle needlessly.
  - v1 <= pix_en, b1 <= in_box.
- Stage 2: the RAM samples READ_ADDR; v2 <= v1, b2 <= b1.
- Stage 3 (registered outputs):
  - pix_valid <= v2.
  - pix_opaque <= v2 && b2 && ram_data!=TRANSPARENT.
  - pix_idx <= opaque ? ram_data : 0.
- Partial clipping at the right and bottom screen edges falls out of the comparisons. Negative positions are not supported.
- Cycles with pix_en=0 still advance the pipeline and produce a bubble (pix_valid=0).

## Timing
- Latency: a coordinate sampled with pix_en at edge k appears on pix_* after edge k+3. Throughput is one pixel per cycle.
- frame_start and pix_en in the same cycle: that pixel uses the old shadow values. New values apply from the next sample.
- Reset values: READ_ADDR=0, pix_valid=0, pix_opaque=0, pix_idx=0. All pipeline valid/box bits clear.
- RESET mid-frame flushes all in-flight pixels. Nothing is output until pix_en is sampled again, and the sprite stays hidden until the next frame_start with spr_enable=1.
- No backpressure: the consumer must accept every pix_valid cycle.

## Structure
- Shared package sprite_pkg:
  - typedef pal_idx_t (logic [3:0]).
  - constant TRANSPARENT_IDX.
  - coordinate width 10.
  - RAM address width 19.
- One sub-module: sprite_shadow_regs (frame_start-loaded latch with frame clamp).
- The address multiply uses constant parameters only (shift/add synthesises). No runtime multiplier.

## Test plan
- Reset, frame_start with SpriteX=100, SpriteY=50, frame 0, enable=1; sweep DrawX 98..121 on DrawY=50. Required: pix_valid 3 cycles after each sample; READ_ADDR 0..19 for DrawX 100..119; pix_opaque=0 at 98, 99, 120 and 121.
- Same setup with flip_h=1, DrawX=100, DrawY=51. Required: READ_ADDR=39; DrawX=119 gives READ_ADDR=20.
- FRAMES=3, frame_sel=2, DrawX=x, DrawY=y → READ_ADDR=1600. frame_sel=7 clamps to the same result.
- Preload RAM word 5 with TRANSPARENT and word 6 with 4'h9. Required: pix_opaque=0 and pix_idx=0 for the first pixel; pix_opaque=1 and pix_idx=9 for the second.
- Change SpriteX mid-frame without frame_start: the box is unchanged. Pulse frame_start together with pix_en: that pixel uses the old box, and the next pixel uses the new box.
- Assert RESET while three valid pixels are in flight. Required: pix_valid=0 immediately and for the three following cycles; spr_enable is treated as 0 until the next frame_start.
